// File: rtl/proc_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, FSM states,
// ALU operations and immediate formats, plus the immediate/ALU decode helpers.
package proc_pkg;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SLT = 3'd2;
    localparam logic [2:0] F3_XOR = 3'd4;
    localparam logic [2:0] F3_OR  = 3'd6;
    localparam logic [2:0] F3_AND = 3'd7;
    localparam logic [2:0] F3_BEQ = 3'd0;
    localparam logic [2:0] F3_BNE = 3'd1;
    localparam logic [2:0] F3_BLT = 3'd4;
    localparam logic [2:0] F3_BGE = 3'd5;
    localparam logic [2:0] F3_W   = 3'd2;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_t t);
        case (t)
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   return {ir[31:12], 12'b0};
            IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return {{20{ir[31]}}, ir[31:20]};
        endcase
    endfunction

    function automatic logic alu_f3_ok(input logic [2:0] f3);
        return f3 inside {F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND};
    endfunction

    function automatic alu_op_t alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            F3_SLT:  return ALU_SLT;
            F3_XOR:  return ALU_XOR;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return sub ? ALU_SUB : ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_processor_reg_file.sv
// NREG x 32 register file: two combinational read ports, one synchronous write
// port, x0 never written so it always reads zero.
module reg_file #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [31:0]   wd,
    output logic [31:0]   rd1,
    output logic [31:0]   rd2
);

    logic [31:0] regs [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

endmodule

// File: rtl/multicycle_processor.sv
// Multi-cycle RV32I-subset core sharing one instruction/data memory port with a
// req/ready handshake; bus outputs are registered from the FSM's next state.
module multicycle_processor
    import proc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          NREG     = 32,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic        trap,
    output logic [31:0] pc_dbg
);

    localparam int         AW      = $clog2(NREG);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    alu_op_t     alu_op;
    imm_t        imm_sel;
    logic [31:0] pc, oldpc, ir, a, b, alu_out, mdr;
    logic [31:0] pc_n, alu_out_n, imm, op_b, alu_res, rd1, rd2, wb_data;
    logic [7:0]  wait_cnt;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic        xfer, timeout_hit, illegal, taken, rf_we;
    logic        use_rs1, use_rs2, use_rd;

    assign opcode      = ir[6:0];
    assign f3          = ir[14:12];
    assign f7          = ir[31:25];
    assign xfer        = mem_req && mem_ready;
    assign timeout_hit = (TIMEOUT != 0) && mem_req && !mem_ready && (wait_cnt == TO_LAST);
    assign pc_dbg      = pc;

    // Decode: legality only considers the register fields the format actually uses.
    always_comb begin
        imm_sel = IMM_I;
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        use_rd  = 1'b1;
        case (opcode)
            OP_LUI:    begin imm_sel = IMM_U; use_rs1 = 1'b0; end
            OP_JAL:    begin imm_sel = IMM_J; use_rs1 = 1'b0; end
            OP_JALR:   illegal = (f3 != F3_ADD);
            OP_BRANCH: begin
                imm_sel = IMM_B; use_rs2 = 1'b1; use_rd = 1'b0;
                illegal = !(f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE});
            end
            OP_LOAD:   illegal = (f3 != F3_W);
            OP_STORE:  begin
                imm_sel = IMM_S; use_rs2 = 1'b1; use_rd = 1'b0;
                illegal = (f3 != F3_W);
            end
            OP_IMM:    begin alu_op = alu_of(f3, 1'b0); illegal = !alu_f3_ok(f3); end
            OP_REG:    begin
                alu_op  = alu_of(f3, f7[5]);
                use_rs2 = 1'b1;
                illegal = !alu_f3_ok(f3) ||
                          !((f7 == F7_BASE) || (f7 == F7_SUB && f3 == F3_ADD));
            end
            OP_SYSTEM: begin use_rs1 = 1'b0; use_rd = 1'b0; end
            default:   begin illegal = 1'b1; use_rs1 = 1'b0; use_rd = 1'b0; end
        endcase
        if ((use_rs1 && int'(ir[19:15]) >= NREG) ||
            (use_rs2 && int'(ir[24:20]) >= NREG) ||
            (use_rd  && int'(ir[11:7])  >= NREG))
            illegal = 1'b1;
        imm = imm_gen(ir, imm_sel);
    end

    always_comb begin
        op_b = (opcode == OP_REG) ? b : imm;
        case (alu_op)
            ALU_SUB: alu_res = a - op_b;
            ALU_AND: alu_res = a & op_b;
            ALU_OR:  alu_res = a | op_b;
            ALU_XOR: alu_res = a ^ op_b;
            ALU_SLT: alu_res = {31'b0, $signed(a) < $signed(op_b)};
            default: alu_res = a + op_b;
        endcase
        case (f3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) < $signed(b));
            F3_BGE:  taken = !($signed(a) < $signed(b));
            default: taken = 1'b0;
        endcase
        case (opcode)
            OP_LOAD:         wb_data = mdr;
            OP_JAL, OP_JALR: wb_data = oldpc + 32'd4;
            OP_LUI:          wb_data = imm;
            default:         wb_data = alu_out;
        endcase
    end

    assign rf_we = (state == S_WB);

    reg_file #(.NREG(NREG)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (ir[15 +: AW]),
        .ra2 (ir[20 +: AW]),
        .we  (rf_we),
        .wa  (ir[7 +: AW]),
        .wd  (wb_data),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // Next state plus the PC/ALUout values the registered bus outputs need a cycle early.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        alu_out_n = alu_out;
        case (state)
            S_FETCH: begin
                if (timeout_hit) state_n = S_TRAP;
                else if (xfer) begin
                    state_n = S_DECODE;
                    pc_n    = pc + 32'd4;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_n = S_TRAP;
                    pc_n    = oldpc;
                end else if (opcode == OP_SYSTEM) begin
                    state_n = S_HALT;
                    pc_n    = oldpc;
                end else state_n = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_BRANCH: begin
                        state_n = S_FETCH;
                        if (taken) pc_n = oldpc + imm;
                    end
                    OP_LOAD, OP_STORE: begin
                        state_n   = S_MEM;
                        alu_out_n = a + imm;
                    end
                    default: begin
                        state_n   = S_WB;
                        alu_out_n = alu_res;
                    end
                endcase
            end
            S_MEM: begin
                if (timeout_hit) begin
                    state_n = S_TRAP;
                    pc_n    = oldpc;
                end else if (xfer) state_n = (opcode == OP_STORE) ? S_FETCH : S_WB;
            end
            S_WB: begin
                state_n = S_FETCH;
                if (opcode == OP_JAL)  pc_n = oldpc + imm;
                if (opcode == OP_JALR) pc_n = (a + imm) & ~32'd1;
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            oldpc     <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            wait_cnt  <= '0;
            halted    <= 1'b0;
            trap      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            pc       <= pc_n;
            alu_out  <= alu_out_n;
            wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
            if (state == S_FETCH && xfer) begin
                ir    <= mem_rdata;
                oldpc <= pc;
            end
            if (state == S_DECODE) begin
                a <= rd1;
                b <= rd2;
            end
            if (state == S_MEM && xfer) mdr <= mem_rdata;
            if (state_n == S_HALT) halted <= 1'b1;
            if (state_n == S_TRAP) trap   <= 1'b1;
            mem_req   <= (state_n == S_FETCH) || (state_n == S_MEM);
            mem_we    <= (state_n == S_MEM) && (opcode == OP_STORE);
            mem_addr  <= (state_n == S_MEM)   ? alu_out_n :
                         (state_n == S_FETCH) ? pc_n : '0;
            mem_wdata <= (state_n == S_MEM) ? b : '0;
        end
    end

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed bench for multicycle_processor: expected bus transfers are queued by
// the stimulus and checked by a monitor at every completed handshake.
module tb_multicycle_processor;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    localparam logic [31:0] ECALL   = 32'h0000_0073;
    localparam logic [31:0] NOSTALL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

    logic [31:0] mem [256];
    logic [31:0] img [256];
    logic        do_load = 1'b0;
    int          wait_n = 0;
    int          wcnt = 0;
    logic [31:0] stall_addr = NOSTALL;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   trap_cyc = -1;
    int   stall_cyc = -1;
    txn_t exp_q[$];
    int   hs_t[$];

    always #5 clk = ~clk;

    multicycle_processor #(.RESET_PC(32'h0), .NREG(16), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .trap      (trap),
        .pc_dbg    (pc_dbg)
    );

    // Memory model: ready after wait_n wait cycles, never for the stall address.
    assign mem_ready = mem_req && (wcnt == wait_n) && (mem_addr != stall_addr);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_req || mem_ready) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
        if (do_load) mem <= img;
        else if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [11:0] i;
        i = 12'(imm);
        return {i, 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] i;
        i = 12'(imm);
        return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input logic [2:0] f3);
        logic [12:0] i;
        i = 13'(imm);
        return {i[12], i[10:5], 5'(rs2), 5'(rs1), f3, i[4:1], i[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] i;
        i = 21'(imm);
        return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'h6F};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic exp_f(input logic [31:0] addr);
        exp_q.push_back('{we: 1'b0, addr: addr, wdata: 32'h0});
    endtask

    task automatic exp_s(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back('{we: 1'b1, addr: addr, wdata: data});
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
    endtask

    task automatic start_prog(input int waits, input logic [31:0] stall);
        rst        = 1'b0;
        wait_n     = waits;
        stall_addr = stall;
        do_load    = 1'b1;
        @(posedge clk);
        #1 do_load = 1'b0;
        hs_t.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_prog(input int waits, input logic [31:0] stall, input string nm);
        start_prog(waits, stall);
        for (int i = 0; i < 400 && !(halted || trap); i++) @(negedge clk);
        if (!(halted || trap)) begin
            checks++;
            errors++;
            $display("FAIL %s_run_timeout got halted=%b trap=%b want either set", nm, halted, trap);
        end
        repeat (2) @(negedge clk);
        chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: handshakes against the expectation queue, and bus stability during waits.
    initial begin
        logic        pend;
        logic        p_we;
        logic [31:0] p_addr, p_wdata;
        txn_t        e;
        pend = 1'b0;
        p_we = 1'b0;
        p_addr = '0;
        p_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend      = 1'b0;
                trap_cyc  = -1;
                stall_cyc = -1;
            end else begin
                if (trap && trap_cyc < 0) trap_cyc = cyc;
                if (mem_req && mem_addr == stall_addr && stall_cyc < 0) stall_cyc = cyc;
                if (pend && !trap) begin
                    checks++;
                    if (!mem_req || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata) begin
                        errors++;
                        $display("FAIL hold_stable got req=%b addr=%h we=%b wdata=%h want req=1 addr=%h we=%b wdata=%h",
                                 mem_req, mem_addr, mem_we, mem_wdata, p_addr, p_we, p_wdata);
                    end
                end
                if (mem_req && mem_ready) begin
                    hs_t.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_txn got we=%b addr=%h wdata=%h want none", mem_we, mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                            errors++;
                            $display("FAIL txn got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                        end
                    end
                end
                pend    = mem_req && !mem_ready;
                p_we    = mem_we;
                p_addr  = mem_addr;
                p_wdata = mem_wdata;
            end
        end
    end

    initial begin
        clear_img();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req",    {31'b0, mem_req}, 32'd0);
        chk("rst_we",     {31'b0, mem_we},  32'd0);
        chk("rst_addr",   mem_addr,         32'h0);
        chk("rst_wdata",  mem_wdata,        32'h0);
        chk("rst_halted", {31'b0, halted},  32'd0);
        chk("rst_trap",   {31'b0, trap},    32'd0);
        chk("rst_pc",     pc_dbg,           32'h0);

        // 1: zero-wait ALU sequence, x3 = 5 + -3 observed through a store
        clear_img();
        img[0] = enc_i(5, 0, 3'd0, 1, 7'h13);
        img[1] = enc_i(-3, 0, 3'd0, 2, 7'h13);
        img[2] = enc_r(7'h00, 2, 1, 3'd0, 3);
        img[3] = enc_s(64, 3, 0);
        img[4] = ECALL;
        exp_f(32'h0); exp_f(32'h4); exp_f(32'h8); exp_f(32'hC);
        exp_s(32'd64, 32'd2); exp_f(32'h10);
        run_prog(0, NOSTALL, "t1");
        chk("t1_cycles", 32'(hs_t[3] - hs_t[0]), 32'd12);
        chk("t1_halted", {31'b0, halted}, 32'd1);
        chk("t1_trap",   {31'b0, trap},   32'd0);
        chk("t1_pc",     pc_dbg,          32'h10);

        // 2: three wait cycles per request, store then reload through memory
        clear_img();
        img[0] = enc_i(5, 0, 3'd0, 1, 7'h13);
        img[1] = enc_i(-3, 0, 3'd0, 2, 7'h13);
        img[2] = enc_r(7'h00, 2, 1, 3'd0, 3);
        img[3] = enc_s(8, 3, 0);
        img[4] = enc_i(8, 0, 3'd2, 4, 7'h03);
        img[5] = enc_s(64, 4, 0);
        img[6] = ECALL;
        exp_f(32'h0); exp_f(32'h4); exp_f(32'h8); exp_f(32'hC);
        exp_s(32'd8, 32'd2); exp_f(32'h10); exp_f(32'd8); exp_f(32'h14);
        exp_s(32'd64, 32'd2); exp_f(32'h18);
        run_prog(3, NOSTALL, "t2");
        chk("t2_mem8",   mem[2],          32'd2);
        chk("t2_mem64",  mem[16],         32'd2);
        chk("t2_halted", {31'b0, halted}, 32'd1);

        // 3: signed branches; skipped slots hold an illegal word
        clear_img();
        img[0] = enc_i(5, 0, 3'd0, 1, 7'h13);
        img[1] = enc_i(-3, 0, 3'd0, 2, 7'h13);
        img[2] = enc_b(8, 1, 2, 3'd4);
        img[3] = 32'hFFFF_FFFF;
        img[4] = enc_b(8, 1, 2, 3'd5);
        img[5] = enc_b(8, 1, 1, 3'd0);
        img[6] = 32'hFFFF_FFFF;
        img[7] = ECALL;
        exp_f(32'h0); exp_f(32'h4); exp_f(32'h8); exp_f(32'h10);
        exp_f(32'h14); exp_f(32'h1C);
        run_prog(0, NOSTALL, "t3");
        chk("t3_branch_cycles", 32'(hs_t[4] - hs_t[3]), 32'd3);
        chk("t3_halted", {31'b0, halted}, 32'd1);
        chk("t3_trap",   {31'b0, trap},   32'd0);
        chk("t3_pc",     pc_dbg,          32'h1C);

        // 4: jal/jalr link and targets, x0 write discarded
        clear_img();
        img[0]  = enc_j(32, 0);
        img[8]  = enc_j(16, 1);
        img[9]  = enc_i(7, 0, 3'd0, 0, 7'h13);
        img[10] = enc_s(64, 0, 0);
        img[11] = ECALL;
        img[12] = enc_i(0, 1, 3'd0, 0, 7'h67);
        img[16] = 32'hDEAD_BEEF;
        exp_f(32'h0); exp_f(32'h20); exp_f(32'h30); exp_f(32'h24);
        exp_f(32'h28); exp_s(32'd64, 32'd0); exp_f(32'h2C);
        run_prog(0, NOSTALL, "t4");
        chk("t4_jal_cycles", 32'(hs_t[2] - hs_t[1]), 32'd4);
        chk("t4_mem64", mem[16], 32'h0);
        chk("t4_pc",    pc_dbg,  32'h2C);

        // 5a: all-ones word is illegal
        clear_img();
        img[0] = 32'hFFFF_FFFF;
        exp_f(32'h0);
        run_prog(0, NOSTALL, "t5a");
        chk("t5a_trap_delay", 32'(trap_cyc - hs_t[0]), 32'd2);
        chk("t5a_trap",   {31'b0, trap},    32'd1);
        chk("t5a_halted", {31'b0, halted},  32'd0);
        chk("t5a_req",    {31'b0, mem_req}, 32'd0);
        chk("t5a_pc",     pc_dbg,           32'h0);

        // 5b: x15 usable with 16 registers, x17 traps
        clear_img();
        img[0] = enc_i(9, 0, 3'd0, 15, 7'h13);
        img[1] = enc_s(64, 15, 0);
        img[2] = enc_r(7'h00, 0, 0, 3'd0, 17);
        exp_f(32'h0); exp_f(32'h4); exp_s(32'd64, 32'd9); exp_f(32'h8);
        run_prog(0, NOSTALL, "t5b");
        chk("t5b_trap", {31'b0, trap},    32'd1);
        chk("t5b_req",  {31'b0, mem_req}, 32'd0);
        chk("t5b_pc",   pc_dbg,           32'h8);

        // 6a: fetch of 0xC never acknowledged, timeout after four wait cycles
        clear_img();
        img[0] = enc_i(5, 0, 3'd0, 1, 7'h13);
        img[1] = enc_i(-3, 0, 3'd0, 2, 7'h13);
        img[2] = enc_r(7'h00, 2, 1, 3'd0, 3);
        img[3] = ECALL;
        exp_f(32'h0); exp_f(32'h4); exp_f(32'h8);
        run_prog(0, 32'hC, "t6a");
        chk("t6a_wait_cycles", 32'(trap_cyc - stall_cyc), 32'd4);
        chk("t6a_trap", {31'b0, trap},    32'd1);
        chk("t6a_req",  {31'b0, mem_req}, 32'd0);
        chk("t6a_pc",   pc_dbg,           32'hC);

        // 6b: asynchronous reset in the middle of a stalled fetch
        exp_f(32'h0); exp_f(32'h4); exp_f(32'h8);
        start_prog(0, 32'hC);
        for (int i = 0; i < 100 && stall_cyc < 0; i++) @(negedge clk);
        if (stall_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL t6b_stall_timeout got no stalled request want one");
        end
        @(negedge clk);
        chk("t6b_req_before", {31'b0, mem_req}, 32'd1);
        chk("t6b_pc_before",  pc_dbg,           32'hC);
        #2 rst = 1'b0;
        #1;
        chk("t6b_req_async",  {31'b0, mem_req}, 32'd0);
        chk("t6b_pc_async",   pc_dbg,           32'h0);
        chk("t6b_addr_async", mem_addr,         32'h0);
        chk("t6b_trap_async", {31'b0, trap},    32'd0);
        chk("t6b_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
